// File: rtl/io_stage_if.sv
// Bundle of the ex->io->wb handshake, data SRAM response and back-pass signals.
// The master side is the surrounding pipeline; the slave side is io_stage.
interface io_stage_if;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] alu_result;
    logic [4:0]  destination_register;
    logic        register_write;
    logic        result_is_from_memory;
  } ex_to_io_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] result;
    logic [4:0]  destination_register;
    logic        register_write;
  } io_to_wb_t;

  typedef struct packed {
    logic [4:0]  address;
    logic [31:0] value;
    logic        pending;
  } back_pass_t;

  logic        wb_allow_in;
  logic        io_allow_in;
  ex_to_io_t   ex_to_io_bus;
  logic        data_read_valid;
  logic [31:0] data_read_data;
  io_to_wb_t   io_to_wb_bus;
  back_pass_t  io_to_id_back_pass_bus;
  logic        data_timeout;

  modport master (
    output wb_allow_in,
    output ex_to_io_bus,
    output data_read_valid,
    output data_read_data,
    input  io_allow_in,
    input  io_to_wb_bus,
    input  io_to_id_back_pass_bus,
    input  data_timeout
  );

  modport slave (
    input  wb_allow_in,
    input  ex_to_io_bus,
    input  data_read_valid,
    input  data_read_data,
    output io_allow_in,
    output io_to_wb_bus,
    output io_to_id_back_pass_bus,
    output data_timeout
  );

endinterface

// File: rtl/io_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for the load
// response when needed, and hands the result to writeback with a back-pass.
module io_stage #(
  parameter int unsigned RESPONSE_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  io_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_DATA = 2'd1,
    READY     = 2'd2
  } state_t;

  state_t      state;

  logic [31:0] hold_pc;
  logic [31:0] hold_alu;
  logic [4:0]  hold_dest;
  logic        hold_rw;
  logic        hold_mem;
  logic [31:0] result_buf;

  logic [4:0]  wait_cnt;
  logic [4:0]  wait_cnt_inc;
  logic        timeout_flag;

  logic        io_ready_go;
  logic        allow;
  logic        capture;
  logic        wb_valid;
  logic        occupied;
  logic [31:0] result;

  // A load result is forwarded straight from the SRAM in its response cycle.
  always_comb begin
    io_ready_go = 1'b0;
    result      = hold_alu;
    case (state)
      WAIT_DATA: begin
        io_ready_go = bus.data_read_valid;
        result      = bus.data_read_data;
      end
      READY: begin
        io_ready_go = 1'b1;
        result      = hold_mem ? result_buf : hold_alu;
      end
      default: begin
        io_ready_go = 1'b0;
        result      = hold_alu;
      end
    endcase
  end

  assign occupied     = (state != EMPTY);
  assign allow        = !reset || !occupied || (io_ready_go && bus.wb_allow_in);
  assign wb_valid     = reset && occupied && io_ready_go;
  assign capture      = reset && allow && bus.ex_to_io_bus.valid;
  assign wait_cnt_inc = (wait_cnt == 5'd31) ? wait_cnt : wait_cnt + 5'd1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= EMPTY;
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else if (allow) begin
      if (bus.ex_to_io_bus.valid) begin
        if (bus.ex_to_io_bus.result_is_from_memory) begin
          state    <= WAIT_DATA;
          wait_cnt <= '0;
        end else begin
          state    <= READY;
        end
      end else begin
        state <= EMPTY;
      end
    end else if (state == WAIT_DATA) begin
      // Only reachable here when writeback stalls or no response has come yet.
      if (bus.data_read_valid) begin
        state <= READY;
      end else begin
        wait_cnt <= wait_cnt_inc;
        if ({27'd0, wait_cnt_inc} >= RESPONSE_TIMEOUT) begin
          timeout_flag <= 1'b1;
        end
      end
    end
  end

  // Data registers carry no reset; they are only visible while valid is high.
  always_ff @(posedge clock) begin
    if (capture) begin
      hold_pc   <= bus.ex_to_io_bus.program_count;
      hold_alu  <= bus.ex_to_io_bus.alu_result;
      hold_dest <= bus.ex_to_io_bus.destination_register;
      hold_rw   <= bus.ex_to_io_bus.register_write;
      hold_mem  <= bus.ex_to_io_bus.result_is_from_memory;
    end
    if (reset && !allow && state == WAIT_DATA && bus.data_read_valid) begin
      result_buf <= bus.data_read_data;
    end
  end

  assign bus.io_allow_in  = allow;
  assign bus.data_timeout = timeout_flag;

  always_comb begin
    bus.io_to_wb_bus       = '0;
    bus.io_to_wb_bus.valid = wb_valid;
    if (wb_valid) begin
      bus.io_to_wb_bus.program_count        = hold_pc;
      bus.io_to_wb_bus.result               = result;
      bus.io_to_wb_bus.destination_register = hold_dest;
      bus.io_to_wb_bus.register_write       = hold_rw;
    end
  end

  always_comb begin
    bus.io_to_id_back_pass_bus         = '0;
    bus.io_to_id_back_pass_bus.pending = reset && (state == WAIT_DATA) && !bus.data_read_valid;
    if (reset && occupied && hold_rw) begin
      bus.io_to_id_back_pass_bus.address = hold_dest;
    end
    if (occupied) begin
      bus.io_to_id_back_pass_bus.value = result;
    end
  end

endmodule

// File: tb/tb_io_stage.sv
// Bench for io_stage: directed scenarios plus a long randomized run, all
// compared against a transaction-level model of the stage's occupancy.
module tb_io_stage;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  io_stage_if bus ();

  io_stage #(.RESPONSE_TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: at most one instruction held; a load becomes deliverable once its data is known.
  bit          m_occ, m_load, m_got, m_rw, m_to;
  logic [31:0] m_pc, m_alu, m_data;
  logic [4:0]  m_dest;
  int          m_wait;

  bit          m_present, exp_valid, exp_allow, exp_pending;
  logic [31:0] exp_res;
  logic [4:0]  exp_addr;

  task automatic model_eval();
    m_present   = m_occ && (!m_load || m_got || bus.data_read_valid);
    exp_res     = !m_load ? m_alu : (m_got ? m_data : bus.data_read_data);
    exp_valid   = reset && m_present;
    exp_allow   = !reset || !m_occ || (m_present && bus.wb_allow_in);
    exp_pending = reset && m_occ && m_load && !m_got && !bus.data_read_valid;
    exp_addr    = (reset && m_occ && m_rw) ? m_dest : 5'd0;
  endtask

  task automatic model_advance();
    model_eval();
    if (!reset) begin
      m_occ = 0; m_wait = 0; m_to = 0;
    end else if (exp_allow) begin
      if (bus.ex_to_io_bus.valid) begin
        m_occ  = 1;
        m_pc   = bus.ex_to_io_bus.program_count;
        m_alu  = bus.ex_to_io_bus.alu_result;
        m_dest = bus.ex_to_io_bus.destination_register;
        m_rw   = bus.ex_to_io_bus.register_write;
        m_load = bus.ex_to_io_bus.result_is_from_memory;
        m_got  = 0;
        if (m_load) m_wait = 0;
      end else begin
        m_occ = 0;
      end
    end else if (m_occ && m_load && !m_got) begin
      if (bus.data_read_valid) begin
        m_got = 1; m_data = bus.data_read_data;
      end else begin
        m_wait = (m_wait + 1 > 31) ? 31 : m_wait + 1;
        if (m_wait >= 16) m_to = 1;
      end
    end
  endtask

  task automatic drive_ex(input bit v, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [4:0] dest, input bit rw, input bit mem);
    bus.ex_to_io_bus.valid                 = v;
    bus.ex_to_io_bus.program_count         = pc;
    bus.ex_to_io_bus.alu_result            = alu;
    bus.ex_to_io_bus.destination_register  = dest;
    bus.ex_to_io_bus.register_write        = rw;
    bus.ex_to_io_bus.result_is_from_memory = mem;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clock);
    model_advance();
    @(negedge clock);
  endtask

  task automatic idle();
    drive_ex(0, '0, '0, '0, 0, 0);
    bus.wb_allow_in = 1'b1; bus.data_read_valid = 1'b0; bus.data_read_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_ex(1, 32'h40, 32'h55, 5'd3, 1, 1);
    bus.wb_allow_in = 1'b1; bus.data_read_valid = 1'b1; bus.data_read_data = 32'h1;
    tick(); tick(); settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.io_to_wb_bus.valid); else n_pass++;
    n_checks++; if (bus.io_allow_in !== 1'b1) $display("FAIL rst_allow: got %b exp 1", bus.io_allow_in); else n_pass++;
    n_checks++; if (bus.io_to_id_back_pass_bus.address !== 5'd0) $display("FAIL rst_addr: got %0d exp 0", bus.io_to_id_back_pass_bus.address); else n_pass++;
    n_checks++; if (bus.io_to_id_back_pass_bus.pending !== 1'b0) $display("FAIL rst_pending: got %b exp 0", bus.io_to_id_back_pass_bus.pending); else n_pass++;
    n_checks++; if (bus.data_timeout !== 1'b0) $display("FAIL rst_timeout: got %b exp 0", bus.data_timeout); else n_pass++;
    reset = 1'b1;
    idle();
    settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b0) $display("FAIL post_rst_valid: got %b exp 0", bus.io_to_wb_bus.valid); else n_pass++;
    n_checks++; if (bus.io_allow_in !== 1'b1) $display("FAIL post_rst_allow: got %b exp 1", bus.io_allow_in); else n_pass++;
    tick();
  endtask

  task automatic test_alu_path();
    idle();
    drive_ex(1, 32'h100, 32'h1234, 5'd5, 1, 0);
    tick();
    idle(); settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b1) $display("FAIL alu_valid: got %b exp 1", bus.io_to_wb_bus.valid); else n_pass++;
    n_checks++; if (bus.io_to_wb_bus.result !== 32'h1234) $display("FAIL alu_result: got %h exp 00001234", bus.io_to_wb_bus.result); else n_pass++;
    n_checks++; if (bus.io_to_id_back_pass_bus.address !== 5'd5) $display("FAIL alu_bp_addr: got %0d exp 5", bus.io_to_id_back_pass_bus.address); else n_pass++;
    n_checks++; if (bus.io_to_id_back_pass_bus.value !== 32'h1234) $display("FAIL alu_bp_value: got %h exp 00001234", bus.io_to_id_back_pass_bus.value); else n_pass++;
    tick(); settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b0) $display("FAIL alu_drained: got %b exp 0", bus.io_to_wb_bus.valid); else n_pass++;
  endtask

  task automatic test_load_delay();
    idle();
    drive_ex(1, 32'h300, 32'h0, 5'd7, 1, 1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (bus.io_to_id_back_pass_bus.pending !== 1'b1) $display("FAIL ld_pending[%0d]: got %b exp 1", i, bus.io_to_id_back_pass_bus.pending); else n_pass++;
      n_checks++; if (bus.io_allow_in !== 1'b0) $display("FAIL ld_allow[%0d]: got %b exp 0", i, bus.io_allow_in); else n_pass++;
      n_checks++; if (bus.io_to_wb_bus.valid !== 1'b0) $display("FAIL ld_valid_early[%0d]: got %b exp 0", i, bus.io_to_wb_bus.valid); else n_pass++;
      tick();
    end
    bus.data_read_valid = 1'b1; bus.data_read_data = 32'hDEADBEEF;
    settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b1) $display("FAIL ld_valid: got %b exp 1", bus.io_to_wb_bus.valid); else n_pass++;
    n_checks++; if (bus.io_to_wb_bus.result !== 32'hDEADBEEF) $display("FAIL ld_result: got %h exp deadbeef", bus.io_to_wb_bus.result); else n_pass++;
    n_checks++; if (bus.io_to_id_back_pass_bus.pending !== 1'b0) $display("FAIL ld_pending_resp: got %b exp 0", bus.io_to_id_back_pass_bus.pending); else n_pass++;
    tick();
    idle(); settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b0) $display("FAIL ld_drained: got %b exp 0", bus.io_to_wb_bus.valid); else n_pass++;
  endtask

  task automatic test_load_stall();
    int delivered;
    delivered = 0;
    idle();
    drive_ex(1, 32'h400, 32'h0, 5'd9, 1, 1);
    tick();
    idle();
    bus.wb_allow_in = 1'b0; bus.data_read_valid = 1'b1; bus.data_read_data = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin bus.data_read_valid = 1'b0; bus.data_read_data = 32'h0; end
      bus.wb_allow_in = (c >= 3);
      settle();
      if (c < 4) begin
        n_checks++; if (bus.io_to_wb_bus.result !== 32'hDEADBEEF) $display("FAIL stall_result[%0d]: got %h exp deadbeef", c, bus.io_to_wb_bus.result); else n_pass++;
      end
      if (bus.io_to_wb_bus.valid && bus.wb_allow_in) delivered++;
      tick();
    end
    n_checks++; if (delivered !== 1) $display("FAIL stall_deliveries: got %0d exp 1", delivered); else n_pass++;
  endtask

  task automatic test_back_to_back();
    idle(); tick();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive_ex(1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 5'(i + 1), 1, 0);
      else       drive_ex(0, '0, '0, '0, 0, 0);
      settle();
      if (i > 0) begin
        n_checks++; if (bus.io_to_wb_bus.valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b exp 1", i, bus.io_to_wb_bus.valid); else n_pass++;
        n_checks++; if (bus.io_to_wb_bus.program_count !== 32'h200 + 32'(4 * (i - 1))) $display("FAIL b2b_pc[%0d]: got %h exp %h", i, bus.io_to_wb_bus.program_count, 32'h200 + 32'(4 * (i - 1))); else n_pass++;
        n_checks++; if (bus.io_to_wb_bus.result !== 32'h1000 + 32'(i - 1)) $display("FAIL b2b_result[%0d]: got %h exp %h", i, bus.io_to_wb_bus.result, 32'h1000 + 32'(i - 1)); else n_pass++;
        n_checks++; if (bus.io_allow_in !== 1'b1) $display("FAIL b2b_allow[%0d]: got %b exp 1", i, bus.io_allow_in); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    idle();
    drive_ex(1, 32'h500, 32'h0, 5'd0, 0, 1);
    tick();
    idle();
    for (int k = 1; k <= 16; k++) begin
      settle();
      n_checks++; if (bus.data_timeout !== 1'b0) $display("FAIL to_early[%0d]: got %b exp 0", k, bus.data_timeout); else n_pass++;
      tick();
    end
    settle();
    n_checks++; if (bus.data_timeout !== 1'b1) $display("FAIL to_set: got %b exp 1", bus.data_timeout); else n_pass++;
    n_checks++; if (bus.io_to_id_back_pass_bus.pending !== 1'b1) $display("FAIL to_still_waiting: got %b exp 1", bus.io_to_id_back_pass_bus.pending); else n_pass++;
    bus.data_read_valid = 1'b1; bus.data_read_data = 32'hCAFE0001;
    settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b1) $display("FAIL to_late_valid: got %b exp 1", bus.io_to_wb_bus.valid); else n_pass++;
    n_checks++; if (bus.io_to_id_back_pass_bus.address !== 5'd0) $display("FAIL to_nowrite_addr: got %0d exp 0", bus.io_to_id_back_pass_bus.address); else n_pass++;
    tick();
    idle(); settle();
    n_checks++; if (bus.data_timeout !== 1'b1) $display("FAIL to_sticky: got %b exp 1", bus.data_timeout); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    idle();
    drive_ex(1, 32'h600, 32'h0, 5'd4, 1, 1);
    tick();
    idle(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b0) $display("FAIL rw_valid: got %b exp 0", bus.io_to_wb_bus.valid); else n_pass++;
    n_checks++; if (bus.data_timeout !== 1'b0) $display("FAIL rw_timeout: got %b exp 0", bus.data_timeout); else n_pass++;
    n_checks++; if (bus.io_allow_in !== 1'b1) $display("FAIL rw_allow: got %b exp 1", bus.io_allow_in); else n_pass++;
    bus.data_read_valid = 1'b1; bus.data_read_data = 32'h12345678;
    settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b0) $display("FAIL rw_pulse_ignored: got %b exp 0", bus.io_to_wb_bus.valid); else n_pass++;
    tick();
    idle(); settle();
    n_checks++; if (bus.io_to_wb_bus.valid !== 1'b0) $display("FAIL rw_after_pulse: got %b exp 0", bus.io_to_wb_bus.valid); else n_pass++;
    n_checks++; if (bus.io_to_id_back_pass_bus.pending !== 1'b0) $display("FAIL rw_pending: got %b exp 0", bus.io_to_id_back_pass_bus.pending); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(99) != 0);
      drive_ex($urandom_range(9) < 6, $urandom, $urandom, 5'($urandom_range(31)),
               $urandom_range(9) < 8, $urandom_range(9) < 4);
      bus.wb_allow_in     = ($urandom_range(9) < 7);
      bus.data_read_valid = ($urandom_range(9) < 3);
      bus.data_read_data  = $urandom;
      settle();
      n_checks++; if (bus.io_to_wb_bus.valid !== exp_valid) $display("FAIL rnd_valid@%0d: got %b exp %b", c, bus.io_to_wb_bus.valid, exp_valid); else n_pass++;
      n_checks++; if (bus.io_allow_in !== exp_allow) $display("FAIL rnd_allow@%0d: got %b exp %b", c, bus.io_allow_in, exp_allow); else n_pass++;
      n_checks++; if (bus.io_to_id_back_pass_bus.pending !== exp_pending) $display("FAIL rnd_pending@%0d: got %b exp %b", c, bus.io_to_id_back_pass_bus.pending, exp_pending); else n_pass++;
      n_checks++; if (bus.io_to_id_back_pass_bus.address !== exp_addr) $display("FAIL rnd_addr@%0d: got %0d exp %0d", c, bus.io_to_id_back_pass_bus.address, exp_addr); else n_pass++;
      n_checks++; if (bus.data_timeout !== m_to) $display("FAIL rnd_timeout@%0d: got %b exp %b", c, bus.data_timeout, m_to); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (bus.io_to_wb_bus.program_count !== m_pc) $display("FAIL rnd_pc@%0d: got %h exp %h", c, bus.io_to_wb_bus.program_count, m_pc); else n_pass++;
        n_checks++; if (bus.io_to_wb_bus.result !== exp_res) $display("FAIL rnd_result@%0d: got %h exp %h", c, bus.io_to_wb_bus.result, exp_res); else n_pass++;
        n_checks++; if (bus.io_to_wb_bus.destination_register !== m_dest) $display("FAIL rnd_dest@%0d: got %0d exp %0d", c, bus.io_to_wb_bus.destination_register, m_dest); else n_pass++;
        n_checks++; if (bus.io_to_wb_bus.register_write !== m_rw) $display("FAIL rnd_rw@%0d: got %b exp %b", c, bus.io_to_wb_bus.register_write, m_rw); else n_pass++;
      end
      if (reset && m_occ) begin
        n_checks++; if (bus.io_to_id_back_pass_bus.value !== exp_res) $display("FAIL rnd_bp_value@%0d: got %h exp %h", c, bus.io_to_id_back_pass_bus.value, exp_res); else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    idle();
    @(negedge clock);
    test_reset();
    test_alu_path();
    test_load_delay();
    test_load_stall();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_stage.md
IO_STAGE -- requirements
Module: io_stage

Interface
REQ-001 SHALL have parameter RESPONSE_TIMEOUT, default 16, meaning the max cycles a load waits for data before data_timeout asserts.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port wb_allow_in, input, 1, meaning the writeback stage accepts data this cycle.
REQ-005 SHALL have port io_allow_in, output, 1, meaning this stage accepts ex_to_io_bus this cycle.
REQ-006 SHALL have port ex_to_io_bus, input, struct, with fields valid, program_count[31:0], alu_result[31:0], destination_register[4:0], register_write, result_is_from_memory.
REQ-007 SHALL have port data_read_valid, input, 1, meaning the data SRAM read response is present this cycle.
REQ-008 SHALL have port data_read_data, input, 32, meaning the data SRAM read word.
REQ-009 SHALL have port io_to_wb_bus, output, struct, with fields valid, program_count[31:0], result[31:0], destination_register[4:0], register_write.
REQ-010 SHALL have port io_to_id_back_pass_bus, output, struct, with fields address[4:0], value[31:0], pending.
REQ-011 SHALL have port data_timeout, output, 1, a sticky load-response timeout flag.

Function
REQ-012 SHALL use FSM states EMPTY, WAIT_DATA, and READY; its reset state SHALL be EMPTY.
REQ-013 SHALL set io_allow_in = (state==EMPTY) || (io_ready_go && wb_allow_in).
REQ-014 SHALL capture all ex_to_io_bus fields into internal registers on io_allow_in && ex_to_io_bus.valid.
- Next state SHALL be WAIT_DATA if result_is_from_memory=1; otherwise READY.
- Hold registers SHALL be unchanged when no capture occurs.
REQ-015 SHALL go to EMPTY on io_allow_in && !ex_to_io_bus.valid.
REQ-016 In WAIT_DATA, io_ready_go SHALL equal data_read_valid, and the result SHALL be data_read_data passed combinationally in that cycle.
REQ-017 In WAIT_DATA with data_read_valid=1 and wb_allow_in=0, SHALL latch data_read_data into a result buffer and go to READY.
REQ-018 In READY, io_ready_go SHALL be 1; result SHALL be the buffered load data for loads, otherwise alu_result.
REQ-019 SHALL ignore data_read_valid in EMPTY and READY; no state or data change.
REQ-020 SHALL set io_to_wb_bus.valid = (state!=EMPTY) && io_ready_go; all other wb fields SHALL come from the hold registers and the selected result.
REQ-021 SHALL allow a simultaneous hand-off to wb and capture of a new ex entry in one cycle, giving zero-bubble throughput of 1 instruction/cycle for non-loads.
REQ-022 SHALL give latency of exactly 1 cycle from capture to wb valid for non-loads; for loads, the response cycle.
REQ-023 Back-pass address SHALL be destination_register when state!=EMPTY && register_write, else 0.
REQ-024 Back-pass value SHALL be the selected result; pending SHALL be 1 iff state==WAIT_DATA && !data_read_valid.
REQ-025 A 5-bit wait counter SHALL clear on entry to WAIT_DATA and increment each WAIT_DATA cycle without a response, saturating at 31.
REQ-026 data_timeout SHALL set when the counter reaches RESPONSE_TIMEOUT and SHALL clear only on reset.
- Timeout SHALL NOT alter the FSM; the stage keeps waiting.
REQ-027 SHALL make register_write=0 with valid=1 still pass to wb, with back-pass address 0.

Reset
REQ-028 On reset==0 at a clock edge, state SHALL become EMPTY, the wait counter 0, and data_timeout 0; any in-flight instruction SHALL be dropped.
REQ-029 During and after reset: io_to_wb_bus.valid=0, io_allow_in=1, back-pass address=0, and pending=0.
REQ-030 Hold and buffer data registers need no reset; their outputs SHALL NOT be observable while valid=0.

Verification
REQ-031 Non-load path: alu_result=0x1234, dest=5, wb_allow_in=1 -> next cycle wb valid=1, result=0x1234; back-pass addr=5, value=0x1234.
REQ-032 Load response delayed 3 cycles -> pending=1 for 3 cycles, io_allow_in=0; response 0xDEADBEEF -> wb valid with 0xDEADBEEF in the same cycle.
REQ-033 Load response arrives with wb_allow_in=0 -> READY holds 0xDEADBEEF; wb_allow_in=1 two cycles later -> delivered once, with no duplicate.
REQ-034 Back-to-back non-loads, wb_allow_in=1 -> 4 instructions out in 4 consecutive cycles, in order.
REQ-035 No response for RESPONSE_TIMEOUT=16 cycles -> data_timeout=1 after 16 cycles and stays 1 after a late response.
REQ-036 reset=0 asserted while in WAIT_DATA -> next cycle state EMPTY, wb valid=0, data_timeout=0; a subsequent data_read_valid pulse is ignored.
